// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   Instruction queue between the fetch stage and the decoder. Fetched
//   {pc, inst} pairs are buffered in a circular FIFO. The oldest entry is
//   presented to the decoder with a valid/ready handshake (first-word
//   fall-through). The queue tells fetch to stop early (SLACK free slots left)
//   and drops all entries on a ROB jump flush.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active-low
//   rdy        in   global ready; low freezes every register
//   in_valid   in   fetch -> queue: entry present
//   in_inst    in   [31:0] instruction word from fetch
//   in_pc      in   [31:0] pc of in_inst
//   full       out  queue -> fetch: stop sending new entries
//   out_valid  out  queue -> decoder: head entry valid
//   out_inst   out  [31:0] head instruction
//   out_pc     out  [31:0] head pc
//   out_ready  in   decoder takes the head entry this cycle
//   flush      in   ROB jump: discard all entries
//   count      out  [ADDR_W:0] current occupancy (debug)
// -----------------------------------------------------------------------------
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SLACK  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_valid,
  input  logic [31:0]       in_inst,
  input  logic [31:0]       in_pc,
  output logic              full,
  output logic              out_valid,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  input  logic              out_ready,
  input  logic              flush,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] LP_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_FULL_TH = (ADDR_W+1)'(DEPTH - SLACK);

  logic [63:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;

  logic              w_active;
  logic              w_nonempty;
  logic              w_enq;
  logic              w_deq;
  logic [63:0]       w_head_entry;

  // Flush and freeze both block any transfer in the current cycle.
  assign w_active   = rdy & ~flush;
  assign w_nonempty = (r_count != '0);

  // An in_valid while completely full is a protocol violation and is ignored.
  assign w_enq      = w_active & in_valid & (r_count < LP_DEPTH);
  assign out_valid  = w_active & w_nonempty;
  assign w_deq      = out_valid & out_ready;

  assign w_head_entry = r_mem[r_head];
  assign out_pc       = w_nonempty ? w_head_entry[63:32] : '0;
  assign out_inst     = w_nonempty ? w_head_entry[31:0]  : '0;

  // Derived from registered occupancy only, so fetch sees no comb path from
  // its own in_valid.
  assign full  = (r_count >= LP_FULL_TH);
  assign count = r_count;

  // Storage holds data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail] <= {in_pc, in_inst};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_deq) begin
          r_head <= r_head + 1'b1;
        end
        // Simultaneous enq+deq leaves occupancy unchanged.
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        full;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        flush;
  logic [4:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] insts [3];

  inst_queue #(.DEPTH(16), .ADDR_W(4), .SLACK(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .in_valid  (in_valid),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .full      (full),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    insts[0] = 32'h0000_0013;
    insts[1] = 32'h0010_0093;
    insts[2] = 32'h0020_0113;

    rst = 1'b0; rdy = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);
    cyc();
    rst = 1'b1;
    cyc();

    // 1: three entries, then pop in order
    in_valid = 1'b1; in_pc = 32'h0; in_inst = insts[0];
    #1;
    chk("t1_no_bypass", out_valid, 0);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("t1_lat_valid", out_valid, 1);
    chk("t1_lat_pc", out_pc, 32'h0);
    push(32'h4, insts[1]);
    push(32'h8, insts[2]);
    #1;
    chk("t1_count", count, 3);
    chk("t1_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_pop_valid", out_valid, 1);
      chk("t1_pop_pc", out_pc, 32'(4 * i));
      chk("t1_pop_inst", out_inst, insts[i]);
      cyc();
    end
    #1;
    chk("t1_empty_valid", out_valid, 0);
    chk("t1_empty_count", count, 0);
    out_ready = 1'b0;

    // 2: fill to 16, full threshold, overflow ignored
    for (int i = 0; i < 16; i++) begin
      push(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      if (i == 12) chk("t2_full_at13", full, 0);
      if (i == 13) chk("t2_full_at14", full, 1);
    end
    chk("t2_count16", count, 16);
    push(32'hDEAD, 32'hDEAD_BEEF);
    chk("t2_ovf_count", count, 16);
    chk("t2_ovf_full", full, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t2_pop_pc", out_pc, 32'h100 + 32'(4 * i));
      chk("t2_pop_inst", out_inst, 32'hA000_0000 + 32'(i));
      cyc();
      if (i == 1) chk("t2_full_at14_drain", full, 1);
      if (i == 2) chk("t2_full_at13_drain", full, 0);
    end
    out_ready = 1'b0;
    #1;
    chk("t2_empty", count, 0);

    // 3: steady count=5 with enq+deq every cycle, across wrap
    for (int i = 0; i < 5; i++) push(32'h1000 + 32'(4 * i), 32'(i));
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      in_pc = 32'h1000 + 32'(4 * (k + 5));
      in_inst = 32'(k + 5);
      #1;
      chk("t3_pc", out_pc, 32'h1000 + 32'(4 * k));
      chk("t3_count", count, 5);
      cyc();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("t3_tail_pc", out_pc, 32'h1000 + 32'(4 * (40 + j)));
      cyc();
    end
    out_ready = 1'b0;
    #1;
    chk("t3_empty", count, 0);

    // 4: flush with count=7
    for (int i = 0; i < 7; i++) push(32'h2000 + 32'(4 * i), 32'(i));
    chk("t4_count7", count, 7);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3000; out_ready = 1'b1;
    #1;
    chk("t4_flush_valid", out_valid, 0);
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("t4_count0", count, 0);
    chk("t4_valid0", out_valid, 0);
    push(32'h4000, 32'h4);
    #1;
    chk("t4_new_count", count, 1);
    chk("t4_new_pc", out_pc, 32'h4000);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    #1;
    chk("t4_drained", count, 0);

    // 5: freeze
    for (int i = 0; i < 3; i++) push(32'h5000 + 32'(4 * i), 32'(i));
    rdy = 1'b0; in_valid = 1'b1; in_pc = 32'h6000; out_ready = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_frz_valid", out_valid, 0);
      chk("t5_frz_count", count, 3);
      chk("t5_frz_pc", out_pc, 32'h5000);
      cyc();
    end
    rdy = 1'b1; in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_resume_pc", out_pc, 32'h5000 + 32'(4 * i));
      chk("t5_resume_valid", out_valid, 1);
      cyc();
    end
    out_ready = 1'b0;
    #1;
    chk("t5_empty", count, 0);

    // 6: asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) push(32'h7100 + 32'(4 * i), 32'(i));
    chk("t6_count4", count, 4);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_pc", out_pc, 0);
    cyc();
    rst = 1'b1;
    cyc();
    in_valid = 1'b1; in_pc = 32'h7000; in_inst = 32'h77;
    #1;
    chk("t6_push_no_bypass", out_valid, 0);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("t6_push_valid", out_valid, 1);
    chk("t6_push_pc", out_pc, 32'h7000);
    chk("t6_push_count", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
